// File: rtl/vote_session_ctrl.sv
// vote_session_ctrl: one 4-voter ballot session with timeout and one-hot verdict
// Ports:
//   clk, rst (async, active-high)
//   start        open a session (accepted in IDLE and DONE)
//   abort        cancel everything, back to IDLE
//   vote_valid/vote_val  per-voter ballot strobe and value (1 = yes)
//   busy         high in COLLECT and EVAL
//   voted        voters whose ballot has been latched
//   yes_count    yes tally, valid in DONE
//   result       {fail, tie, pass} one-hot
//   result_valid high throughout DONE
//   timed_out    session closed by timeout
module vote_session_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] vote_valid,
  input  logic [3:0] vote_val,
  output logic       busy,
  output logic [3:0] voted,
  output logic [2:0] yes_count,
  output logic [2:0] result,
  output logic       result_valid,
  output logic       timed_out
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, COLLECT, EVAL, DONE} state_t;
  state_t state, next;
  logic [3:0] ballot, acc, yes;
  logic [TW-1:0] timer;
  logic all_in, tmo, opening;
  logic [2:0] cnt;
  assign acc = state == COLLECT ? vote_valid & ~voted : 4'b0;
  assign all_in = (voted | acc) == 4'b1111;
  assign tmo = timer == TW'(TIMEOUT_CYCLES - 1);
  assign opening = start && (state == IDLE || state == DONE);
  assign yes = ballot & voted;
  assign cnt = {2'b0, yes[0]} + {2'b0, yes[1]} + {2'b0, yes[2]} + {2'b0, yes[3]};
  always_comb begin
    next = state;
    if (abort) next = IDLE;
    else if (opening) next = COLLECT;
    else if (state == COLLECT) next = (all_in || tmo) ? EVAL : COLLECT;
    else if (state == EVAL) next = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      voted <= '0;
      ballot <= '0;
      yes_count <= '0;
      result <= '0;
      timed_out <= 1'b0;
      timer <= '0;
      busy <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      busy <= next == COLLECT || next == EVAL;
      result_valid <= next == DONE;
      if (abort || opening) begin
        voted <= '0;
        ballot <= '0;
        yes_count <= '0;
        result <= '0;
        timed_out <= 1'b0;
        timer <= '0;
      end else if (state == COLLECT) begin
        voted <= voted | acc;
        ballot <= (ballot & ~acc) | (vote_val & acc);
        timer <= timer + TW'(1);
        // completion in the timeout cycle wins over the timeout flag
        timed_out <= tmo && !all_in;
      end else if (state == EVAL) begin
        yes_count <= cnt;
        result <= {cnt <= 3'd1, cnt == 3'd2, cnt >= 3'd3};
      end
    end
endmodule
